// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Multi-cycle fetch/decode/execute controller for the 16-bit accumulator
//   machine. Owns PC, IR, MAR, MBR and AC, sequences a synchronous single-port
//   memory with 1-cycle read latency and an external combinational ALU.
//
// Parameters
//   RESET_PC    PC value loaded on reset
//
// Ports
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   run         start request, sampled in IDLE only
//   mem_addr    memory address (PC in IDLE/FETCH/DECODE/HALT, MAR otherwise)
//   mem_wdata   memory write data (AC)
//   mem_we      memory write enable (STORE in EXEC only)
//   mem_rdata   memory read data, valid the cycle after the address
//   alu_op      ALU opcode decoded from IR[15:12]
//   alu_a       ALU operand 1 (AC)
//   alu_b       ALU operand 2 (MBR)
//   alu_result  ALU result (combinational)
//   pc, ac, ir  architectural register taps
//   halted      high while in HALT
//   instr_done  one-cycle pulse on the last cycle of every instruction
// ----------------------------------------------------------------------------
module control_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    output logic [3:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_result,
    output logic [15:0] pc,
    output logic [15:0] ac,
    output logic [15:0] ir,
    output logic        halted,
    output logic        instr_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_READ, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_LOADI = 4'hC;
    localparam logic [3:0] OP_CLEAR = 4'hD;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mbr_q, mbr_d;
    logic [15:0] ac_q, ac_d;
    logic        halted_q, halted_d;

    logic [3:0]  op;
    logic        needs_read;

    assign op = ir_q[15:12];
    // LOAD and the memory-operand ALU ops take the READ/WB detour.
    assign needs_read = (op == OP_LOAD) || ((op >= OP_ADD) && (op <= OP_XOR));

    always_comb begin
        case (op)
            OP_ADD:  alu_op = 4'b0000;
            OP_SUB:  alu_op = 4'b0001;
            OP_AND:  alu_op = 4'b1000;
            OP_OR:   alu_op = 4'b1001;
            OP_XOR:  alu_op = 4'b1010;
            OP_SHL:  alu_op = 4'b0100;
            OP_SHR:  alu_op = 4'b0101;
            default: alu_op = 4'b0000;
        endcase
    end

    // NOTE: every next-state variable takes its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mar_d   = mar_q;
        mbr_d   = mbr_q;
        ac_d    = ac_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = mem_rdata;
                mar_d   = {4'h0, mem_rdata[11:0]};
                pc_d    = pc_q + 16'd1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (needs_read) begin
                    state_d = S_READ;
                end else begin
                    case (op)
                        OP_SHL, OP_SHR: ac_d = alu_result;
                        OP_JUMP:        pc_d = mar_q;
                        OP_JZ:          if (ac_q == 16'h0000) pc_d = mar_q;
                        OP_LOADI:       ac_d = mar_q;
                        OP_CLEAR:       ac_d = 16'h0000;
                        OP_HALT:        state_d = S_HALT;
                        default:        ;
                    endcase
                end
            end
            S_READ: begin
                mbr_d   = mem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                ac_d    = (op == OP_LOAD) ? mbr_q : alu_result;
                state_d = S_FETCH;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
        halted_d = (state_d == S_HALT);
    end

    // NOTE: reset takes priority over the computed next state, so a reset
    // landing mid-instruction discards any pending register update.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            mar_q    <= 16'h0000;
            mbr_q    <= 16'h0000;
            ac_q     <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the same pre-edge state.
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            mbr_q    <= mbr_d;
            ac_q     <= ac_d;
            halted_q <= halted_d;
        end
    end

    assign mem_addr   = ((state_q == S_EXEC) || (state_q == S_READ) || (state_q == S_WB))
                        ? mar_q : pc_q;
    assign mem_wdata  = ac_q;
    // Gated with reset_n so a reset arriving during STORE's EXEC blocks the write.
    assign mem_we     = reset_n && (state_q == S_EXEC) && (op == OP_STORE);
    assign instr_done = reset_n && (((state_q == S_EXEC) && !needs_read) || (state_q == S_WB));
    assign alu_a      = ac_q;
    assign alu_b      = mbr_q;
    assign pc         = pc_q;
    assign ac         = ac_q;
    assign ir         = ir_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
//   Directed and randomized programs run on the sequencer, compared at every
//   retirement against an instruction-level model of the ISA.
// ----------------------------------------------------------------------------
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0, run = 1'b0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result;
    logic [15:0] pc, ac, ir;
    logic [3:0]  alu_op;
    logic        mem_we, halted, instr_done;

    logic        reset2_n = 1'b0, run2 = 1'b0;
    logic [15:0] mem_addr2, mem_wdata2, mem_rdata2, alu_a2, alu_b2, alu_result2;
    logic [15:0] pc2, ac2, ir2;
    logic [3:0]  alu_op2;
    logic        mem_we2, halted2, instr_done2;

    always #5 clk = ~clk;

    control_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .reset_n(reset_n), .run(run),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .pc(pc), .ac(ac), .ir(ir), .halted(halted), .instr_done(instr_done)
    );

    control_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .reset_n(reset2_n), .run(run2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_we(mem_we2), .mem_rdata(mem_rdata2),
        .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(alu_result2),
        .pc(pc2), .ac(ac2), .ir(ir2), .halted(halted2), .instr_done(instr_done2)
    );

    // Environment: external ALU
    function automatic logic [15:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1000: return a & b;
            4'b1001: return a | b;
            4'b1010: return a ^ b;
            4'b0100: return a << 1;
            4'b0101: return a >> 1;
            default: return 16'h0000;
        endcase
    endfunction
    assign alu_result  = alu_f(alu_op, alu_a, alu_b);
    assign alu_result2 = alu_f(alu_op2, alu_a2, alu_b2);

    // Environment: synchronous memories, bulk-loaded from img on ld_req
    logic [15:0] img  [0:65535];
    logic [15:0] mem  [0:65535];
    logic [15:0] mem2 [0:65535];
    logic        ld_req = 1'b0;

    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < 65536; i++) begin
                mem[i]  <= img[i];
                mem2[i] <= img[i];
            end
        end else begin
            if (mem_we)  mem[mem_addr]   <= mem_wdata;
            if (mem_we2) mem2[mem_addr2] <= mem_wdata2;
        end
        mem_rdata  <= mem[mem_addr];
        mem_rdata2 <= mem2[mem_addr2];
    end

    // Reference model: one call executes one whole instruction
    logic [15:0] m_mem [0:65535];
    logic [15:0] m_pc, m_ac;
    logic        m_halt;

    task automatic model_exec(input logic [15:0] w, output int cyc,
                              output bit wrote, output logic [15:0] waddr);
        logic [15:0] x;
        x     = {4'h0, w[11:0]};
        m_pc  = m_pc + 16'd1;
        cyc   = 3;
        wrote = 1'b0;
        waddr = x;
        case (w[15:12])
            4'h1: begin m_ac = m_mem[x];        cyc = 5; end
            4'h2: begin m_mem[x] = m_ac;        wrote = 1'b1; end
            4'h3: begin m_ac = m_ac + m_mem[x]; cyc = 5; end
            4'h4: begin m_ac = m_ac - m_mem[x]; cyc = 5; end
            4'h5: begin m_ac = m_ac & m_mem[x]; cyc = 5; end
            4'h6: begin m_ac = m_ac | m_mem[x]; cyc = 5; end
            4'h7: begin m_ac = m_ac ^ m_mem[x]; cyc = 5; end
            4'h8: m_ac = {m_ac[14:0], 1'b0};
            4'h9: m_ac = {1'b0, m_ac[15:1]};
            4'hA: m_pc = x;
            4'hB: if (m_ac == 16'h0000) m_pc = x;
            4'hC: m_ac = x;
            4'hD: m_ac = 16'h0000;
            4'hF: m_halt = 1'b1;
            default: ;
        endcase
    endtask

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [15:0] pc_log [0:63];
    logic [15:0] ac_log [0:63];
    int          n_done, tot_cyc;

    task automatic clear_img();
        for (int i = 0; i < 65536; i++) img[i] = 16'h0000;
    endtask

    // Hold reset, load memory image, reset the model and check the reset state.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        run     = 1'b0;
        ld_req  = 1'b1;
        @(negedge clk);
        ld_req = 1'b0;
        for (int i = 0; i < 65536; i++) m_mem[i] = img[i];
        m_pc = 16'h0000; m_ac = 16'h0000; m_halt = 1'b0;
        check("rst_pc", pc, 16'h0000);
        check("rst_ac_ir", {ac, ir}, 32'h0);
        check("rst_flags", {halted, instr_done, mem_we}, 3'b000);
        check("rst_addr", mem_addr, 16'h0000);
    endtask

    // Release reset, optionally idle, then raise run so the next edge fetches.
    task automatic start(input int idle_cycles);
        @(negedge clk);
        reset_n = 1'b1;
        run     = (idle_cycles == 0);
        for (int k = 0; k < idle_cycles; k++) begin
            @(negedge clk);
            check("idle_hold", {instr_done, pc, mem_addr}, {1'b0, m_pc, m_pc});
        end
        run = 1'b1;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (instr_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_program(input int max_instr);
        logic [15:0] w, waddr;
        int          exp_cyc, cyc;
        bit          wrote, ok;
        n_done  = 0;
        tot_cyc = 0;
        for (int i = 0; i < max_instr && !m_halt; i++) begin
            w = m_mem[m_pc];
            model_exec(w, exp_cyc, wrote, waddr);
            wait_done(cyc, ok);
            check("done_seen", ok, 1'b1);
            if (!ok) return;
            check("latency", cyc, exp_cyc);
            @(posedge clk);
            #1;
            check("pc", pc, m_pc);
            check("ac", ac, m_ac);
            check("ir", ir, w);
            check("halted_done", {halted, instr_done}, {m_halt, 1'b0});
            if (wrote) check("store", mem[waddr], m_mem[waddr]);
            pc_log[i] = pc;
            ac_log[i] = ac;
            n_done++;
            tot_cyc += cyc;
        end
        if (m_halt) begin
            repeat (3) @(negedge clk);
            check("halt_stays", {halted, instr_done, mem_we, pc}, {3'b100, m_pc});
        end
    endtask

    initial begin
        int          cyc;
        bit          ok;
        logic [15:0] w;

        // Test 1: LOAD / ADD / STORE / HALT, with a short IDLE wait first
        clear_img();
        img[0] = 16'h1010; img[1] = 16'h3011; img[2] = 16'h2012; img[3] = 16'hF000;
        img[16'h10] = 16'h0005; img[16'h11] = 16'h0007;
        do_reset();
        start(3);
        run_program(10);
        check("t1_m12", mem[16'h12], 16'h000C);
        check("t1_ac", ac, 16'h000C);
        check("t1_pc", pc, 16'h0004);
        check("t1_halted", halted, 1'b1);
        check("t1_ndone", n_done, 4);
        check("t1_cycles", tot_cyc, 16);

        // Test 2: CLEAR, JZ taken, LOADI, SHL
        clear_img();
        img[0] = 16'hD000; img[1] = 16'hB020;
        img[16'h20] = 16'hC0AB; img[16'h21] = 16'h8000; img[16'h22] = 16'hF000;
        do_reset();
        start(0);
        run_program(10);
        check("t2_jz_pc", pc_log[1], 16'h0020);
        check("t2_loadi_pc", pc_log[2], 16'h0021);
        check("t2_shl_ac", ac_log[3], 16'h0156);

        // Test 3: JZ not taken
        clear_img();
        img[0] = 16'hC001; img[1] = 16'hB020; img[2] = 16'hF000;
        do_reset();
        start(0);
        run_program(10);
        check("t3_jz_pc", pc_log[1], 16'h0002);

        // Test 4: SUB wraps, SHR is logical
        clear_img();
        img[0] = 16'hC8FF; img[1] = 16'h4010; img[2] = 16'h9000; img[3] = 16'hF000;
        img[16'h10] = 16'h0900;
        do_reset();
        start(0);
        run_program(10);
        check("t4_sub", ac_log[1], 16'hFFFF);
        check("t4_shr", ac_log[2], 16'h7FFF);

        // Test 5: RESET_PC=FFFF, NOP at FFFF wraps PC to 0000
        clear_img();
        img[16'hFFFF] = 16'h0000; img[0] = 16'hF000;
        do_reset();
        check("t5_rst_pc", pc2, 16'hFFFF);
        reset2_n = 1'b1;
        run2     = 1'b1;
        cyc = 0; ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (instr_done2 === 1'b1) begin ok = 1'b1; break; end
        end
        check("t5_done_seen", ok, 1'b1);
        check("t5_latency", cyc, 3);
        @(posedge clk);
        #1;
        check("t5_pc_wrap", pc2, 16'h0000);
        repeat (4) @(negedge clk);
        check("t5_halt", {halted2, pc2}, {1'b1, 16'h0001});

        // Test 6: reset during STORE's EXEC blocks the write and aborts
        clear_img();
        img[0] = 16'hC055; img[1] = 16'h2030; img[2] = 16'hF000; img[16'h30] = 16'h1234;
        do_reset();
        start(0);
        wait_done(cyc, ok);
        check("t6_loadi_done", ok, 1'b1);
        repeat (3) @(negedge clk);
        check("t6_we_exec", {mem_we, instr_done, mem_addr}, {2'b11, 16'h0030});
        reset_n = 1'b0;
        #1;
        check("t6_we_gated", {mem_we, instr_done}, 2'b00);
        @(posedge clk);
        #1;
        check("t6_word", mem[16'h30], 16'h1234);
        check("t6_regs", {pc, ac, ir}, 48'h0);
        check("t6_flags", {halted, mem_we, instr_done}, 3'b000);
        for (int i = 0; i < 65536; i++) m_mem[i] = mem[i];
        m_pc = 16'h0000; m_ac = 16'h0000; m_halt = 1'b0;
        start(4);
        run_program(10);
        check("t6_rerun_store", mem[16'h30], 16'h0055);

        // Randomized programs against the model
        for (int p = 0; p < 25; p++) begin
            clear_img();
            for (int a = 0; a < 256; a++) begin
                w[15:12] = 4'($urandom_range(0, 15));
                if (w[15:12] == 4'hF && $urandom_range(0, 7) != 0) w[15:12] = 4'h0;
                w[11:0] = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 255));
                img[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : w;
            end
            do_reset();
            start($urandom_range(0, 2));
            run_program(40);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
